// File: rtl/video_pkg.sv
// Shared timing defaults, FSM state encoding and pixel type for the
// 640x480@60 DVI/HDMI raster path.
package video_pkg;

    localparam int H_ACTIVE_DEF        = 640;
    localparam int H_FP_DEF            = 16;
    localparam int H_SYNC_DEF          = 96;
    localparam int H_BP_DEF            = 48;
    localparam int V_ACTIVE_DEF        = 480;
    localparam int V_FP_DEF            = 10;
    localparam int V_SYNC_DEF          = 2;
    localparam int V_BP_DEF            = 33;
    localparam int SYNC_ACTIVE_LOW_DEF = 1;

    localparam int CNT_W  = 10;
    localparam int DATA_W = 24;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef logic [DATA_W-1:0] rgb_t;

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position counters with synchronous clear,
// advance enable and an end-of-frame flag.
module raster_counter
    import video_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_wrap
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic h_wrap;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (adv) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster scheduler: sequences start/stop around PLL lock and enable,
// requests pixels upstream and drives hsync/vsync/de/rgb to the encoders.
module video_timing_ctrl
    import video_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int H_FP            = H_FP_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BP            = H_BP_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_FP            = V_FP_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BP            = V_BP_DEF,
    parameter int SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_lock,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        sof,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb_out,
    output logic        underflow,
    input  logic        clr_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] h_cnt_p0;
    logic [CNT_W-1:0] v_cnt_p0;
    logic             frame_wrap_p0;
    logic             running_p0;
    logic             cnt_clr;
    logic             active_p0;
    logic             hs_on_p0;
    logic             vs_on_p0;
    logic             hsync_p1;
    logic             vsync_p1;
    logic             de_p1;
    rgb_t             rgb_p1;
    logic             underflow_q;

    assign running_p0 = (state_q == RUN) || (state_q == DRAIN);
    // Clearing on lock loss makes the abrupt stop land with counters at zero.
    assign cnt_clr    = !running_p0 || !pll_lock;

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_raster (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .adv        (running_p0),
        .h_cnt      (h_cnt_p0),
        .v_cnt      (v_cnt_p0),
        .frame_wrap (frame_wrap_p0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (pll_lock && enable) state_d = ARM;
            ARM:     state_d = RUN;
            RUN: begin
                // A disable on the last cycle of a frame needs no drain frame.
                if (!enable) state_d = frame_wrap_p0 ? OFF : DRAIN;
            end
            DRAIN: begin
                if (enable)             state_d = RUN;
                else if (frame_wrap_p0) state_d = OFF;
            end
            default: state_d = OFF;
        endcase
        if (!pll_lock) state_d = OFF;
    end

    // Stage p0: decode from state and counter registers only.
    assign active_p0 = running_p0 && (h_cnt_p0 < H_ACT_END) && (v_cnt_p0 < V_ACT_END);
    assign hs_on_p0  = running_p0 && (h_cnt_p0 >= HS_START) && (h_cnt_p0 < HS_END);
    assign vs_on_p0  = running_p0 && (v_cnt_p0 >= VS_START) && (v_cnt_p0 < VS_END);

    assign pix_ready = active_p0;
    assign pix_x     = active_p0 ? h_cnt_p0 : '0;
    assign pix_y     = active_p0 ? v_cnt_p0 : '0;
    assign sof       = active_p0 && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);

    // Stage p1: encoder-facing registers, one cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p1    <= SYNC_IDLE;
            vsync_p1    <= SYNC_IDLE;
            de_p1       <= 1'b0;
            rgb_p1      <= '0;
            underflow_q <= 1'b0;
        end else begin
            hsync_p1 <= hs_on_p0 ^ SYNC_IDLE;
            vsync_p1 <= vs_on_p0 ^ SYNC_IDLE;
            de_p1    <= active_p0;
            rgb_p1   <= (active_p0 && pix_valid) ? pix_rgb : '0;
            if (active_p0 && !pix_valid) begin
                underflow_q <= 1'b1;
            end else if (clr_underflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign hsync     = hsync_p1;
    assign vsync     = vsync_p1;
    assign de        = de_p1;
    assign rgb_out   = rgb_p1;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl with an 8x6 raster
// (4 active pixels x 3 active lines, 48-cycle frame).
module tb_video_timing_ctrl;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_lock = 1'b0;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic        clr_underflow = 1'b0;
    logic        pix_ready, sof, hsync, vsync, de, underflow;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] rgb_out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] sb[$];

    always #5 clk = ~clk;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .enable(enable),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .hsync(hsync), .vsync(vsync),
        .de(de), .rgb_out(rgb_out), .underflow(underflow),
        .clr_underflow(clr_underflow)
    );

    function automatic logic in_act(int k);
        return ((k % HT) < HA) && (((k / HT) % VT) < VA);
    endfunction

    function automatic logic [23:0] pat(int k);
        return {8'(k % HT), 8'((k / HT) % VT), 8'h5A};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then lock+enable; returns at the first RUN cycle (raster index 0).
    task automatic restart();
        rst_n = 1'b0; pll_lock = 1'b0; enable = 1'b0;
        pix_valid = 1'b1; clr_underflow = 1'b0; sb.delete();
        step(); step();
        rst_n = 1'b1;
        step();
        pll_lock = 1'b1; enable = 1'b1;
        step(); step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_checks++; if (hsync !== 1'b1)     begin n_fail++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
        n_checks++; if (vsync !== 1'b1)     begin n_fail++; $display("FAIL rst_vsync got=%b exp=1", vsync); end
        n_checks++; if (de !== 1'b0)        begin n_fail++; $display("FAIL rst_de got=%b exp=0", de); end
        n_checks++; if (rgb_out !== 24'h0)  begin n_fail++; $display("FAIL rst_rgb got=%h exp=0", rgb_out); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow got=%b exp=0", underflow); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", pix_ready); end
        n_checks++; if (sof !== 1'b0)       begin n_fail++; $display("FAIL rst_sof got=%b exp=0", sof); end
        n_checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin
            n_fail++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", pix_x, pix_y);
        end
        rst_n = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (pix_ready !== 1'b0 || de !== 1'b0) begin
                n_fail++; $display("FAIL off_no_lock ready=%b de=%b exp=0,0", pix_ready, de);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_startup_frames();
        logic        prev_act;
        logic [23:0] exp_rgb;
        int          vs_low = 0;
        int          de_hi = 0;
        int          hs_low = 0;
        sb.delete();
        pix_valid = 1'b1;
        pll_lock = 1'b1; enable = 1'b1;
        step();
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL arm_ready got=%b exp=0", pix_ready); end
        step();
        for (int k = 0; k < 2 * FRAME; k++) begin
            prev_act = (k > 0) && in_act(k - 1);
            n_checks++; if (pix_ready !== in_act(k)) begin
                n_fail++; $display("FAIL run_ready k=%0d got=%b exp=%b", k, pix_ready, in_act(k));
            end
            n_checks++; if (sof !== (in_act(k) && (k % FRAME) == 0)) begin
                n_fail++; $display("FAIL run_sof k=%0d got=%b", k, sof);
            end
            n_checks++; if (pix_x !== (in_act(k) ? 10'(k % HT) : 10'd0) ||
                            pix_y !== (in_act(k) ? 10'((k / HT) % VT) : 10'd0)) begin
                n_fail++; $display("FAIL run_xy k=%0d got=%0d,%0d", k, pix_x, pix_y);
            end
            n_checks++; if (de !== prev_act) begin
                n_fail++; $display("FAIL run_de k=%0d got=%b exp=%b", k, de, prev_act);
            end
            n_checks++; if (hsync !== !((k > 0) && ((k - 1) % HT) >= 5 && ((k - 1) % HT) <= 6)) begin
                n_fail++; $display("FAIL run_hsync k=%0d got=%b", k, hsync);
            end
            n_checks++; if (vsync !== !((k > 0) && (((k - 1) / HT) % VT) == 4)) begin
                n_fail++; $display("FAIL run_vsync k=%0d got=%b", k, vsync);
            end
            n_checks++;
            if (prev_act) begin
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL run_rgb_sb k=%0d got=%h exp=<queued pixel>", k, rgb_out);
                end else begin
                    exp_rgb = sb.pop_front();
                    if (rgb_out !== exp_rgb) begin
                        n_fail++; $display("FAIL run_rgb k=%0d got=%h exp=%h", k, rgb_out, exp_rgb);
                    end
                end
            end else if (rgb_out !== 24'h0) begin
                n_fail++; $display("FAIL run_rgb_idle k=%0d got=%h exp=0", k, rgb_out);
            end
            if (vsync === 1'b0) vs_low++;
            if (hsync === 1'b0) hs_low++;
            if (de === 1'b1)    de_hi++;
            pix_rgb = pat(k);
            if (in_act(k)) sb.push_back(pat(k));
            step();
        end
        n_checks++; if (vs_low != 2 * HT) begin n_fail++; $display("FAIL vsync_len got=%0d exp=%0d", vs_low, 2 * HT); end
        n_checks++; if (hs_low != 2 * VT * HS) begin n_fail++; $display("FAIL hsync_len got=%0d exp=%0d", hs_low, 2 * VT * HS); end
        n_checks++; if (de_hi != 2 * HA * VA) begin n_fail++; $display("FAIL de_count got=%0d exp=%0d", de_hi, 2 * HA * VA); end
    endtask

    task automatic test_underflow();
        logic        uf_exp = 1'b0;
        logic        prev_act;
        logic [23:0] exp_rgb;
        restart();
        for (int k = 0; k <= FRAME; k++) begin
            prev_act = (k > 0) && in_act(k - 1);
            n_checks++; if (underflow !== uf_exp) begin
                n_fail++; $display("FAIL uf_flag k=%0d got=%b exp=%b", k, underflow, uf_exp);
            end
            n_checks++;
            if (prev_act) begin
                exp_rgb = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
                if (rgb_out !== exp_rgb || de !== 1'b1) begin
                    n_fail++; $display("FAIL uf_rgb k=%0d got=%h de=%b exp=%h de=1", k, rgb_out, de, exp_rgb);
                end
            end else if (rgb_out !== 24'h0 || de !== 1'b0) begin
                n_fail++; $display("FAIL uf_idle k=%0d got=%h de=%b exp=0 de=0", k, rgb_out, de);
            end
            pix_valid = !(k == 10 || k == 17);
            clr_underflow = (k == 17 || k == 19);
            pix_rgb = pat(k);
            if (in_act(k)) sb.push_back(pix_valid ? pat(k) : 24'h0);
            if (in_act(k) && !pix_valid) uf_exp = 1'b1;
            else if (clr_underflow)      uf_exp = 1'b0;
            step();
        end
        pix_valid = 1'b1;
        clr_underflow = 1'b0;
    endtask

    task automatic test_disable();
        logic exp_de;
        restart();
        for (int k = 0; k < FRAME + 16; k++) begin
            exp_de = (k > 0) && (k - 1 < FRAME) && in_act(k - 1);
            n_checks++; if (pix_ready !== ((k < FRAME) && in_act(k))) begin
                n_fail++; $display("FAIL drain_ready k=%0d got=%b", k, pix_ready);
            end
            n_checks++; if (de !== exp_de || sof !== ((k == 0) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL drain_de_sof k=%0d got=%b,%b exp=%b,%b", k, de, sof, exp_de, k == 0);
            end
            if (k == 8) enable = 1'b0;
            step();
        end
        restart();
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            n_checks++; if (pix_ready !== in_act(k) || sof !== (in_act(k) && (k % FRAME) == 0)) begin
                n_fail++; $display("FAIL resume_ready k=%0d got=%b,%b exp=%b", k, pix_ready, sof, in_act(k));
            end
            if (k == 8)  enable = 1'b0;
            if (k == 33) enable = 1'b1;
            step();
        end
    endtask

    task automatic test_abrupt_stop();
        restart();
        for (int k = 0; k < 10; k++) step();
        pll_lock = 1'b0;
        step();
        n_checks++; if (pix_ready !== 1'b0 || de !== 1'b1) begin
            n_fail++; $display("FAIL lost1 ready=%b de=%b exp=0,1", pix_ready, de);
        end
        step();
        n_checks++; if (de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL lost2 de=%b hs=%b vs=%b rdy=%b exp=0,1,1,0", de, hsync, vsync, pix_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL lost_ready got=%b exp=0", pix_ready); end
        end
        pll_lock = 1'b1;
        step();
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL relock_arm got=%b exp=0", pix_ready); end
        step();
        n_checks++; if (pix_ready !== 1'b1 || sof !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            n_fail++; $display("FAIL relock_sof rdy=%b sof=%b xy=%0d,%0d exp=1,1,0,0", pix_ready, sof, pix_x, pix_y);
        end
        for (int k = 0; k < 37; k++) step();
        pll_lock = 1'b0;
        step();
        n_checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin
            n_fail++; $display("FAIL sync_before hs=%b vs=%b exp=0,0", hsync, vsync);
        end
        step();
        n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0 || pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL sync_after hs=%b vs=%b de=%b rdy=%b exp=1,1,0,0", hsync, vsync, de, pix_ready);
        end
        pll_lock = 1'b1;
    endtask

    task automatic test_async_reset();
        restart();
        for (int k = 0; k < 9; k++) begin
            pix_valid = (k != 1);
            pix_rgb = pat(k);
            step();
        end
        n_checks++; if (underflow !== 1'b1 || de !== 1'b1 || rgb_out !== pat(8)) begin
            n_fail++; $display("FAIL pre_areset uf=%b de=%b rgb=%h exp=1,1,%h", underflow, de, rgb_out, pat(8));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (de !== 1'b0 || rgb_out !== 24'h0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL areset_data de=%b rgb=%h uf=%b exp=0,0,0", de, rgb_out, underflow);
        end
        n_checks++; if (pix_ready !== 1'b0 || sof !== 1'b0 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            n_fail++; $display("FAIL areset_req rdy=%b sof=%b xy=%0d,%0d exp=0,0,0,0", pix_ready, sof, pix_x, pix_y);
        end
        n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin
            n_fail++; $display("FAIL areset_sync hs=%b vs=%b exp=1,1", hsync, vsync);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_startup_frames();
        test_underflow();
        test_disable();
        test_abrupt_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Raster scheduler for the DVI/HDMI output path. It runs in the 25.2 MHz pixel clock domain and generates hsync, vsync and de for the three TMDS channel encoders. It pulls pixels from the frame-buffer/renderer over a valid/ready stream and presents RGB aligned with de. It also sequences start-up and shutdown around PLL lock and a software enable, so encoders only ever see whole, well-formed frames.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync outputs idle high and pulse low

Ports:
- clk  in  1  pixel clock, 25.2 MHz
- rst_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  TMDS PLL locked
- enable  in  1  software video enable
- pix_valid  in  1  upstream pixel available
- pix_rgb  in  24  {R,G,B} pixel, 8 bits each
- pix_ready  out  1  pixel consumed this cycle
- pix_x  out  10  column of the pixel being requested
- pix_y  out  10  row of the pixel being requested
- sof  out  1  start-of-frame pulse, concurrent with request of (0,0)
- hsync, vsync  out  1 each  to encoders (c0/c1), polarity per SYNC_ACTIVE_LOW
- de  out  1  display enable to encoders
- rgb_out  out  24  pixel data to encoders, aligned with de
- underflow  out  1  sticky: a requested pixel was missing
- clr_underflow  in  1  clears underflow

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent. Counters are h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1. h_cnt wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- States:
  - OFF: counters held at 0; de=0; syncs inactive; pix_ready=0.
  - ARM: one cycle; counters cleared.
  - RUN: counters advance every cycle.
  - DRAIN: RUN behaviour continues until the frame ends.
- Transitions:
  - OFF→ARM when pll_lock & enable.
  - ARM→RUN unconditionally.
  - RUN→DRAIN when enable=0.
  - DRAIN→OFF at the wrap h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
  - DRAIN→RUN if enable returns before that wrap.
  - Any state→OFF on the next edge when pll_lock=0 (abrupt; the partial frame is abandoned).
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, in RUN or DRAIN.
- pix_ready = active region; decoded from registers only, with no input-to-output combinational path. pix_x=h_cnt and pix_y=v_cnt when pix_ready=1, else 0.
- sof = active region & h_cnt=0 & v_cnt=0.
- hsync is asserted while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is asserted while v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over whole lines; edges are coincident with h_cnt=0.
- A transfer happens when pix_ready=1. If pix_valid=0 at that point, rgb_out is 0 for that pixel and underflow is set. The raster never stalls.
- underflow: a set and a clr_underflow in the same cycle leave it set.

## Timing
- Reset values: hsync/vsync = inactive level (1 if SYNC_ACTIVE_LOW, else 0); de=0; rgb_out=0; underflow=0; pix_ready=0; sof=0; pix_x=pix_y=0; state OFF.
- hsync, vsync, de and rgb_out are registered and lag the counter by exactly 1 cycle. A pixel accepted at edge N appears on rgb_out with de=1 during cycle N+1.
- First pix_ready comes 2 cycles after pll_lock & enable are both sampled high (OFF→ARM→RUN).
- On pll_lock loss:
  - de drops and syncs go inactive one cycle after the edge at which pll_lock is sampled low.
  - No further pix_ready is issued.
- Frame period in RUN is H_TOTAL*V_TOTAL cycles (420000 at defaults).

## Structure
- Package video_pkg holds:
  - the 640x480@60 default timing constants;
  - the state enum {OFF, ARM, RUN, DRAIN};
  - the 24-bit rgb type.
- Sub-module raster_counter (h_cnt/v_cnt with clear, advance and wrap flags) is instantiated once. The FSM, decode, output registers and underflow flag live in the top.

## Test plan
Use small parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), SYNC_ACTIVE_LOW=1.
- Reset, then pll_lock=enable=1 with pix_valid always 1:
  - first pix_ready 2 cycles later, with sof=1 and x=0, y=0;
  - de high for 4 of every 8 cycles on lines 0–2;
  - hsync low for 2 cycles at h_cnt 5–6, shifted 1 cycle;
  - vsync low for exactly 8 cycles covering line 4.
- Pixel data: drive pix_rgb = {x,y,0x5A}; rgb_out must equal the previous cycle's value whenever de=1, and rgb_out=0 when de=0.
- Underflow: drop pix_valid for pixel (2,1); rgb_out=0 for that pixel and underflow=1 and stays 1; clr_underflow together with a new miss leaves it at 1, and clr_underflow alone clears it.
- Graceful disable: drop enable at line 1. The frame finishes (48-cycle period intact), then OFF; reasserting enable in line 4 keeps RUN with no gap.
- Abrupt stop: drop pll_lock mid-line. de=0, hsync=vsync=1 and pix_ready=0 one cycle later; on relock, a fresh frame starts with sof.
- Reset mid-frame: assert rst_n=0 asynchronously with no clock edge; all outputs return to their reset values immediately.
